// File: rtl/uart_rx_receiver_if.sv
// uart_rx_receiver_if: received-byte valid/ready channel between the UART receiver and its consumer
//   o_data   8  received byte, driven by the receiver
//   o_valid  1  o_data holds an unconsumed byte
//   i_ready  1  consumer accepts the byte; a transfer happens when o_valid & i_ready
//   master   receiver side; slave consumer side
interface uart_rx_receiver_if;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    modport master (output o_data, output o_valid, input i_ready);
    modport slave (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/uart_rx_receiver.sv
// uart_rx_receiver: 8N1 UART receiver delivering bytes on a valid/ready channel with sticky error flags
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset
//   i_rxd        asynchronous serial input, idle high
//   i_clr_err    one-cycle pulse clearing o_frame_err and o_overrun
//   rx           valid/ready byte channel (master side)
//   o_busy       a frame is in progress (FSM not idle)
//   o_frame_err  sticky: stop bit sampled low
//   o_overrun    sticky: byte completed while the holding register was still full
module uart_rx_receiver #(
    parameter int CLK_FREQ_HZ = 25_000_000,
    parameter int BAUD_RATE   = 1_000_000
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_rxd,
    input  logic                i_clr_err,
    uart_rx_receiver_if.master  rx,
    output logic                o_busy,
    output logic                o_frame_err,
    output logic                o_overrun
);
    localparam int DIV  = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;
    logic [1:0]    sync_q, sync_d;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          ferr_set, ovr_set;
    logic          rx_s;
    assign rx_s   = sync_q[1];
    assign sync_d = {sync_q[0], i_rxd};
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = valid_q & ~rx.i_ready;
        ferr_set = 1'b0;
        ovr_set  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                // mid-start-bit check rejects glitches shorter than half a bit
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = S_IDLE;
                        // a byte consumed in this same cycle frees the register
                        if (!valid_q || rx.i_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_set = 1'b1;
                        end
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // a held-low line must return high before a new start bit counts
                cnt_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        // a set event in the clearing cycle wins
        ferr_d = ferr_set | (ferr_q & ~i_clr_err);
        ovr_d  = ovr_set | (ovr_q & ~i_clr_err);
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q  <= 2'b11;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end
    assign rx.o_data   = data_q;
    assign rx.o_valid  = valid_q;
    assign o_busy      = state_q != S_IDLE;
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx_receiver.sv
// tb_uart_rx_receiver: directed self-checking bench for uart_rx_receiver at 25 MHz / 1 Mbaud
module tb_uart_rx_receiver;
    localparam int DIV = 25;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    logic clr = 1'b0;
    logic busy, ferr, ovr;
    int n_cmp = 0;
    int n_err = 0;
    uart_rx_receiver_if bus ();
    uart_rx_receiver #(
        .CLK_FREQ_HZ(25_000_000),
        .BAUD_RATE  (1_000_000)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rxd      (rxd),
        .i_clr_err  (clr),
        .rx         (bus.master),
        .o_busy     (busy),
        .o_frame_err(ferr),
        .o_overrun  (ovr)
    );
    always #20 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            tick(DIV);
        end
        rxd = 1'b1;
    endtask
    initial begin
        bus.i_ready = 1'b0;
        tick(4);
        rst = 1'b0;
        tick(2);
        check("rst_data", bus.o_data, 8'h00);
        check("rst_valid", bus.o_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ferr", ferr, 1'b0);
        check("rst_ovr", ovr, 1'b0);
        // 0xA5 with i_ready high: exact latency and one-cycle valid pulse
        bus.i_ready = 1'b1;
        fork
            send(8'hA5, 1'b1);
            begin
                tick(239);
                check("t1_busy", busy, 1'b1);
                check("t1_valid_pre", bus.o_valid, 1'b0);
                tick(1);
                check("t1_valid", bus.o_valid, 1'b1);
                check("t1_data", bus.o_data, 8'hA5);
                tick(1);
                check("t1_valid_post", bus.o_valid, 1'b0);
            end
        join
        check("t1_busy_end", busy, 1'b0);
        check("t1_ferr", ferr, 1'b0);
        check("t1_ovr", ovr, 1'b0);
        // 0x00 then 0xFF back-to-back with no consumer: second byte overruns
        bus.i_ready = 1'b0;
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        check("t2_data", bus.o_data, 8'h00);
        check("t2_valid", bus.o_valid, 1'b1);
        check("t2_ovr", ovr, 1'b1);
        check("t2_ferr", ferr, 1'b0);
        bus.i_ready = 1'b1;
        tick(1);
        bus.i_ready = 1'b0;
        check("t2_drain", bus.o_valid, 1'b0);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("t2_clr", ovr, 1'b0);
        // 0x3C with a low stop bit, then the line held low for 50 bit times
        send(8'h3C, 1'b0);
        rxd = 1'b0;
        check("t3_ferr", ferr, 1'b1);
        check("t3_valid", bus.o_valid, 1'b0);
        tick(50 * DIV);
        check("t3_break_busy", busy, 1'b1);
        check("t3_break_valid", bus.o_valid, 1'b0);
        rxd = 1'b1;
        tick(DIV);
        check("t3_idle", busy, 1'b0);
        check("t3_valid_end", bus.o_valid, 1'b0);
        check("t3_ovr", ovr, 1'b0);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("t3_clr", ferr, 1'b0);
        // 5-cycle glitch on an idle line
        tick(DIV);
        rxd = 1'b0;
        tick(5);
        rxd = 1'b1;
        check("t4_busy_mid", busy, 1'b1);
        tick(3 * DIV);
        check("t4_busy", busy, 1'b0);
        check("t4_valid", bus.o_valid, 1'b0);
        check("t4_ferr", ferr, 1'b0);
        check("t4_ovr", ovr, 1'b0);
        // reset during data bit 4 of 0x5A while a byte 0xC3 is held
        send(8'hC3, 1'b1);
        check("t5_pre_valid", bus.o_valid, 1'b1);
        check("t5_pre_data", bus.o_data, 8'hC3);
        rxd = 1'b0;
        tick(DIV);
        for (int i = 0; i < 4; i++) begin
            rxd = (8'h5A >> i) & 1;
            tick(DIV);
        end
        rxd = 1'b1;
        tick(DIV / 2);
        check("t5_busy_pre", busy, 1'b1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t5_rst_valid", bus.o_valid, 1'b0);
        check("t5_rst_data", bus.o_data, 8'h00);
        check("t5_rst_busy", busy, 1'b0);
        tick(12 * DIV);
        check("t5_quiet", bus.o_valid, 1'b0);
        send(8'h81, 1'b1);
        check("t5_data", bus.o_data, 8'h81);
        check("t5_valid", bus.o_valid, 1'b1);
        check("t5_ferr", ferr, 1'b0);
        bus.i_ready = 1'b1;
        tick(1);
        bus.i_ready = 1'b0;
        check("t5_drain", bus.o_valid, 1'b0);
        // overrun set in the same cycle as i_clr_err
        send(8'h11, 1'b1);
        check("t6_pre_ovr", ovr, 1'b0);
        fork
            send(8'h22, 1'b1);
            begin
                tick(239);
                clr = 1'b1;
                tick(1);
                clr = 1'b0;
            end
        join
        check("t6_ovr_wins", ovr, 1'b1);
        check("t6_data_kept", bus.o_data, 8'h11);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("t6_lone_clr", ovr, 1'b0);
        // consumer accepts in the stop-sample cycle: new byte loads, no overrun
        fork
            send(8'h33, 1'b1);
            begin
                tick(239);
                bus.i_ready = 1'b1;
                tick(1);
                bus.i_ready = 1'b0;
            end
        join
        check("t7_data", bus.o_data, 8'h33);
        check("t7_valid", bus.o_valid, 1'b1);
        check("t7_ovr", ovr, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
